pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, pipeline clock; state, outputs and counter update on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 each, source registers of the instruction in ID.
REQ-004 SHALL have port id_uses_rt, input, 1, ID instruction reads rt.
REQ-005 SHALL have ports ex_writeReg (input, 5), ex_RegWrite (input, 1) and ex_MemRead (input, 1), the EX-stage destination and controls.
REQ-006 SHALL have ports mem_writeReg (input, 5), mem_RegWrite (input, 1), mem_MemRead (input, 1) and mem_MemWrite (input, 1), the MEM-stage destination and controls.
REQ-007 SHALL have port mem_branch_taken, input, 1, M_Branch AND M_zero.
REQ-008 SHALL have port dmem_ack, input, 1, data memory access complete.
REQ-009 SHALL have ports pc_we, ifid_we, idex_we and exmem_we, output, 1 each, stage-register write enables.
REQ-010 SHALL have ports ifid_flush, idex_flush, exmem_flush and memwb_flush, output, 1 each, load a bubble (all controls 0).
REQ-011 SHALL have port dmem_req, output, 1, data memory access request.
REQ-012 SHALL have port state_o, output, 2, FSM state: RUN=0, LU_STALL=1, BR_FLUSH=2, MEM_WAIT=3.
REQ-013 SHALL have port stall_cnt, output, 16, saturating count of cycles with pc_we=0.

Function
REQ-014 SHALL decode enables and flushes combinationally from the current state and inputs, with zero-cycle latency; state_o and stall_cnt SHALL be registered.
REQ-015 SHALL default to all enables 1, all flushes 0 and dmem_req 0.
REQ-016 SHALL never raise a hazard on register 0.
REQ-017 SHALL detect load-use when ex_MemRead, ex_RegWrite and ex_writeReg!=0 all hold and ex_writeReg matches id_rs, or matches id_rt with id_uses_rt=1.
REQ-018 On load-use, SHALL drive pc_we=0, ifid_we=0 and idex_flush=1, then enter LU_STALL for one cycle and return to RUN.
REQ-019 SHALL assert dmem_req when mem_MemRead or mem_MemWrite is 1, or when in MEM_WAIT.
REQ-020 If dmem_req=1 and dmem_ack=0, SHALL drive all four enables 0 and memwb_flush=1, and enter or stay in MEM_WAIT.
REQ-021 On the dmem_ack=1 cycle, SHALL restore the enables and SHALL return to RUN on the next edge.
REQ-022 On mem_branch_taken=1, SHALL drive ifid_flush, idex_flush and exmem_flush to 1 with pc_we=1, and enter BR_FLUSH for one cycle.
REQ-023 SHALL mask load-use detection while in BR_FLUSH.
REQ-024 SHALL apply priority MEM_WAIT condition > branch taken > load-use > RAW stall.
REQ-025 During a memory freeze, SHALL assert no flush except memwb_flush and SHALL suppress load-use and branch actions.
REQ-026 SHALL increment stall_cnt on every cycle with pc_we=0 and SHALL hold it at 0xFFFF.

Reset
REQ-027 While rst=1, SHALL set state RUN and stall_cnt 0, drive dmem_req 0, all enables 1 and all flushes 1.
REQ-028 SHALL drop dmem_req immediately if rst asserts mid-MEM_WAIT, and SHALL start in RUN with no pending stall after rst deasserts.

Configuration
REQ-029 SHALL take macro FORWARDING_EN: when defined, the datapath forwards from EX/MEM and MEM/WB, and only the load-use hazard stalls.
REQ-030 When FORWARDING_EN is undefined, SHALL also stall on RAW against EX (ex_RegWrite) or MEM (mem_RegWrite) producers, using pc_we=0, ifid_we=0 and idex_flush=1, repeating each cycle while the match holds (at most 2 cycles); WB is covered by write-before-read in the register file.
REQ-031 SHALL keep state_o encoding and stall_cnt identical in both builds.

Verification
REQ-032 SHALL cover load-use: ex_MemRead=1, ex_RegWrite=1, ex_writeReg=8, id_rs=8 -> same cycle pc_we=0, ifid_we=0, idex_flush=1; next cycle state_o=1; stall_cnt=1.
REQ-033 SHALL cover the register-0 guard: the REQ-032 stimulus with ex_writeReg=0 and id_rs=0 -> no stall; stall_cnt unchanged.
REQ-034 SHALL cover memory wait: mem_MemRead=1 with dmem_ack low for 3 cycles, then high -> dmem_req=1 for 4 cycles, enables 0 for 3 cycles, memwb_flush=1 for 3 cycles, state_o=3 during the wait, stall_cnt=3.
REQ-035 SHALL cover branch versus load-use: mem_branch_taken=1 together with the REQ-032 load-use stimulus -> the three flushes=1, pc_we=1, no stall; next cycle state_o=2.
REQ-036 SHALL cover the no-forward build: FORWARDING_EN undefined, mem_RegWrite=1, mem_writeReg=5, id_rt=5, id_uses_rt=1 -> one stall cycle; with FORWARDING_EN defined -> none.
REQ-037 SHALL cover reset and saturation: rst pulsed mid-MEM_WAIT -> dmem_req=0 and state_o=0 immediately; 70000 forced stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-flush and data-memory freeze
// sequencing. Define FORWARDING_EN when the datapath has EX/MEM and MEM/WB bypasses.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_writeReg,
    input  logic        ex_RegWrite,
    input  logic        ex_MemRead,
    input  logic [4:0]  mem_writeReg,
    input  logic        mem_RegWrite,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic        mem_branch_taken,
    input  logic        dmem_ack,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        dmem_req,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t state, state_nx;

    logic hit_ex, hit_mem, load_use, raw, mem_access, freeze;

    always_comb begin
        hit_ex  = (ex_writeReg != '0) &&
                  ((ex_writeReg == id_rs) || (id_uses_rt && (ex_writeReg == id_rt)));
        hit_mem = (mem_writeReg != '0) &&
                  ((mem_writeReg == id_rs) || (id_uses_rt && (mem_writeReg == id_rt)));
        // The ID slot holds a flushed bubble in BR_FLUSH, so its register fields are stale.
        load_use = ex_MemRead && ex_RegWrite && hit_ex && (state != BR_FLUSH);
`ifdef FORWARDING_EN
        raw = 1'b0;
`else
        raw = ((ex_RegWrite && hit_ex) || (mem_RegWrite && hit_mem)) && (state != BR_FLUSH);
`endif
        mem_access = mem_MemRead || mem_MemWrite || (state == MEM_WAIT);
        freeze     = mem_access && !dmem_ack;
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        dmem_req    = 1'b0;
        state_nx    = RUN;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            dmem_req = mem_access;
            if (freeze) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_we    = 1'b0;
                memwb_flush = 1'b1;
                state_nx    = MEM_WAIT;
            end else if (mem_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                state_nx    = BR_FLUSH;
            end else if (load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                state_nx   = LU_STALL;
            end else if (raw) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
            // The acknowledge cycle always lands back in RUN, whatever else was decoded.
            if ((state == MEM_WAIT) && !freeze) begin
                state_nx = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_we && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign state_o = state;

endmodule
